// File: rtl/tl_ul_link_buffer.sv
// TileLink-UL link buffer sitting in front of the A/D channel protocol monitor.
//
// Decouples a master port from a slave port with one FIFO per channel and caps
// the number of A beats the slave has accepted without a matching D beat.
//
// Ports:
//   clock, reset         single clock, synchronous active-high reset
//   in_a_*  / out_a_*    A channel, master side in, slave side out (84-bit payload)
//   in_d_*  / out_d_*    D channel, slave side in, master side out (49-bit payload)
//   inflight             outstanding A beats at the slave
//   err_unexpected_d     sticky: a D beat arrived with nothing outstanding

module tl_ul_link_buffer #(
    parameter int unsigned A_DEPTH      = 2,
    parameter int unsigned D_DEPTH      = 2,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        in_a_valid,
    output logic        in_a_ready,
    input  logic [83:0] in_a_bits,

    output logic        out_a_valid,
    input  logic        out_a_ready,
    output logic [83:0] out_a_bits,

    input  logic        in_d_valid,
    output logic        in_d_ready,
    input  logic [48:0] in_d_bits,

    output logic        out_d_valid,
    input  logic        out_d_ready,
    output logic [48:0] out_d_bits,

    output logic [3:0]  inflight,
    output logic        err_unexpected_d
);

    localparam int unsigned AAW = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
    localparam int unsigned ACW = $clog2(A_DEPTH + 1);
    localparam int unsigned DAW = (D_DEPTH > 1) ? $clog2(D_DEPTH) : 1;
    localparam int unsigned DCW = $clog2(D_DEPTH + 1);

    // A channel storage
    logic [83:0]    a_mem_q [A_DEPTH];
    logic [AAW-1:0] a_wptr_q, a_wptr_d;
    logic [AAW-1:0] a_rptr_q, a_rptr_d;
    logic [ACW-1:0] a_count_q, a_count_d;

    // D channel storage
    logic [48:0]    d_mem_q [D_DEPTH];
    logic [DAW-1:0] d_wptr_q, d_wptr_d;
    logic [DAW-1:0] d_rptr_q, d_rptr_d;
    logic [DCW-1:0] d_count_q, d_count_d;

    logic [3:0] inflight_q, inflight_d;
    logic       err_q, err_d;

    logic a_enq, a_deq, d_enq, d_deq;

    // Ready depends only on occupancy, so a full FIFO refuses a beat even when
    // it is being drained on the same edge.
    assign in_a_ready  = (a_count_q != ACW'(A_DEPTH));
    assign in_d_ready  = (d_count_q != DCW'(D_DEPTH));

    // The inflight gate uses registered state only; no input-to-valid path.
    assign out_a_valid = (a_count_q != '0) && (inflight_q != 4'(MAX_INFLIGHT));
    assign out_d_valid = (d_count_q != '0);

    assign out_a_bits  = a_mem_q[a_rptr_q];
    assign out_d_bits  = d_mem_q[d_rptr_q];

    assign inflight         = inflight_q;
    assign err_unexpected_d = err_q;

    assign a_enq = in_a_valid  & in_a_ready;
    assign a_deq = out_a_valid & out_a_ready;
    assign d_enq = in_d_valid  & in_d_ready;
    assign d_deq = out_d_valid & out_d_ready;

    always_comb begin
        a_wptr_d  = a_wptr_q;
        a_rptr_d  = a_rptr_q;
        a_count_d = a_count_q;
        if (a_enq) begin
            a_wptr_d = (a_wptr_q == AAW'(A_DEPTH - 1)) ? '0 : a_wptr_q + 1'b1;
        end
        if (a_deq) begin
            a_rptr_d = (a_rptr_q == AAW'(A_DEPTH - 1)) ? '0 : a_rptr_q + 1'b1;
        end
        unique case ({a_enq, a_deq})
            2'b10:   a_count_d = a_count_q + 1'b1;
            2'b01:   a_count_d = a_count_q - 1'b1;
            default: a_count_d = a_count_q;
        endcase
    end

    always_comb begin
        d_wptr_d  = d_wptr_q;
        d_rptr_d  = d_rptr_q;
        d_count_d = d_count_q;
        if (d_enq) begin
            d_wptr_d = (d_wptr_q == DAW'(D_DEPTH - 1)) ? '0 : d_wptr_q + 1'b1;
        end
        if (d_deq) begin
            d_rptr_d = (d_rptr_q == DAW'(D_DEPTH - 1)) ? '0 : d_rptr_q + 1'b1;
        end
        unique case ({d_enq, d_deq})
            2'b10:   d_count_d = d_count_q + 1'b1;
            2'b01:   d_count_d = d_count_q - 1'b1;
            default: d_count_d = d_count_q;
        endcase
    end

    // A D beat with nothing outstanding is still forwarded but latches the error.
    // An A fire on the same edge pairs with it, so that case is not an error.
    always_comb begin
        inflight_d = inflight_q;
        err_d      = err_q;
        if (a_deq && !d_enq) begin
            inflight_d = inflight_q + 4'd1;
        end else if (d_enq && !a_deq) begin
            if (inflight_q != 4'd0) begin
                inflight_d = inflight_q - 4'd1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_wptr_q   <= '0;
            a_rptr_q   <= '0;
            a_count_q  <= '0;
            d_wptr_q   <= '0;
            d_rptr_q   <= '0;
            d_count_q  <= '0;
            inflight_q <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            a_wptr_q   <= a_wptr_d;
            a_rptr_q   <= a_rptr_d;
            a_count_q  <= a_count_d;
            d_wptr_q   <= d_wptr_d;
            d_rptr_q   <= d_rptr_d;
            d_count_q  <= d_count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Payload storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge clock) begin
        if (a_enq) begin
            a_mem_q[a_wptr_q] <= in_a_bits;
        end
        if (d_enq) begin
            d_mem_q[d_wptr_q] <= in_d_bits;
        end
    end

endmodule

// File: tb/tb_tl_ul_link_buffer.sv
// Self-checking bench for tl_ul_link_buffer: a queue-based reference model is
// compared against the DUT every cycle, plus directed literal checks per scenario.

module tb_tl_ul_link_buffer;

    localparam int unsigned A_DEPTH      = 2;
    localparam int unsigned D_DEPTH      = 2;
    localparam int unsigned MAX_INFLIGHT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_a_valid = 1'b0;
    logic        in_a_ready;
    logic [83:0] in_a_bits = '0;
    logic        out_a_valid;
    logic        out_a_ready = 1'b0;
    logic [83:0] out_a_bits;
    logic        in_d_valid = 1'b0;
    logic        in_d_ready;
    logic [48:0] in_d_bits = '0;
    logic        out_d_valid;
    logic        out_d_ready = 1'b0;
    logic [48:0] out_d_bits;
    logic [3:0]  inflight;
    logic        err_unexpected_d;

    tl_ul_link_buffer #(
        .A_DEPTH     (A_DEPTH),
        .D_DEPTH     (D_DEPTH),
        .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_a_valid      (in_a_valid),
        .in_a_ready      (in_a_ready),
        .in_a_bits       (in_a_bits),
        .out_a_valid     (out_a_valid),
        .out_a_ready     (out_a_ready),
        .out_a_bits      (out_a_bits),
        .in_d_valid      (in_d_valid),
        .in_d_ready      (in_d_ready),
        .in_d_bits       (in_d_bits),
        .out_d_valid     (out_d_valid),
        .out_d_ready     (out_d_ready),
        .out_d_bits      (out_d_bits),
        .inflight        (inflight),
        .err_unexpected_d(err_unexpected_d)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [83:0] mk_a(input logic [2:0] op, input logic [4:0] src,
                                         input logic [31:0] addr, input logic [3:0] mask,
                                         input logic [31:0] data);
        return {op, 3'd0, 4'd2, src, addr, mask, data, 1'b0};
    endfunction

    function automatic logic [48:0] mk_d(input logic [2:0] op, input logic [4:0] src,
                                         input logic [31:0] data);
        return {op, 2'd0, 4'd2, src, 1'b0, 1'b0, data, 1'b0};
    endfunction

    // Reference model: plain queues and an outstanding counter.
    logic [83:0] mq_a[$];
    logic [48:0] mq_d[$];
    int          m_infl    = 0;
    bit          m_err     = 0;
    int          m_a_fires = 0;
    bit          chk_en    = 0;

    always @(posedge clock) begin : model
        bit a_rdy, a_val, d_rdy, d_val, a_enq, a_deq, d_enq, d_deq;
        if (reset) begin
            mq_a.delete();
            mq_d.delete();
            m_infl    = 0;
            m_err     = 0;
            m_a_fires = 0;
            chk_en    = 1;
        end else begin
            a_rdy = (mq_a.size() != A_DEPTH);
            d_rdy = (mq_d.size() != D_DEPTH);
            a_val = (mq_a.size() != 0) && (m_infl != MAX_INFLIGHT);
            d_val = (mq_d.size() != 0);
            a_enq = in_a_valid && a_rdy;
            a_deq = a_val && out_a_ready;
            d_enq = in_d_valid && d_rdy;
            d_deq = d_val && out_d_ready;
            if (a_deq) begin
                void'(mq_a.pop_front());
                m_a_fires++;
            end
            if (a_enq) mq_a.push_back(in_a_bits);
            if (d_deq) void'(mq_d.pop_front());
            if (d_enq) mq_d.push_back(in_d_bits);
            if (a_deq && !d_enq) m_infl++;
            else if (d_enq && !a_deq) begin
                if (m_infl == 0) m_err = 1;
                else m_infl--;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            bit ev_a;
            ev_a = (mq_a.size() != 0) && (m_infl != MAX_INFLIGHT);
            check("in_a_ready", {83'd0, in_a_ready}, {83'd0, mq_a.size() != A_DEPTH});
            check("in_d_ready", {83'd0, in_d_ready}, {83'd0, mq_d.size() != D_DEPTH});
            check("out_a_valid", {83'd0, out_a_valid}, {83'd0, ev_a});
            check("out_d_valid", {83'd0, out_d_valid}, {83'd0, mq_d.size() != 0});
            if (ev_a) check("out_a_bits", out_a_bits, mq_a[0]);
            if (mq_d.size() != 0) check("out_d_bits", {35'd0, out_d_bits}, {35'd0, mq_d[0]});
            check("inflight", {80'd0, inflight}, 84'(m_infl));
            check("err_unexpected_d", {83'd0, err_unexpected_d}, {83'd0, m_err});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_a_valid  = 1'b0;
        in_d_valid  = 1'b0;
        out_a_ready = 1'b0;
        out_d_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [83:0] b1, b2, b3, ga;
    logic [48:0] gd;

    initial begin
        // Reset then a single Get beat
        do_reset();
        check("rst_in_a_ready", {83'd0, in_a_ready}, 84'd1);
        check("rst_in_d_ready", {83'd0, in_d_ready}, 84'd1);
        check("rst_out_a_valid", {83'd0, out_a_valid}, 84'd0);
        check("rst_out_d_valid", {83'd0, out_d_valid}, 84'd0);
        check("rst_inflight", {80'd0, inflight}, 84'd0);
        check("rst_err", {83'd0, err_unexpected_d}, 84'd0);
        ga = mk_a(3'd4, 5'd5, 32'h8000_0000, 4'hF, 32'd0);
        out_a_ready = 1'b1;
        in_a_bits   = ga;
        in_a_valid  = 1'b1;
        tick();
        in_a_valid = 1'b0;
        check("t1_out_a_valid", {83'd0, out_a_valid}, 84'd1);
        check("t1_out_a_bits", out_a_bits, ga);
        tick();
        check("t1_inflight", {80'd0, inflight}, 84'd1);
        check("t1_model_infl", 84'(m_infl), 84'd1);
        check("t1_out_a_valid_after", {83'd0, out_a_valid}, 84'd0);

        // FIFO fill: two accepted, third refused until space frees up
        do_reset();
        b1 = mk_a(3'd4, 5'd1, 32'h100, 4'hF, 32'h11);
        b2 = mk_a(3'd4, 5'd2, 32'h104, 4'hF, 32'h22);
        b3 = mk_a(3'd4, 5'd3, 32'h108, 4'hF, 32'h33);
        in_a_valid = 1'b1;
        in_a_bits  = b1;
        tick();
        in_a_bits = b2;
        tick();
        check("t2_full_ready", {83'd0, in_a_ready}, 84'd0);
        in_a_bits = b3;
        tick();
        check("t2_still_full", {83'd0, in_a_ready}, 84'd0);
        check("t2_head_b1", out_a_bits, b1);
        out_a_ready = 1'b1;
        tick();
        check("t2_head_b2", out_a_bits, b2);
        check("t2_ready_again", {83'd0, in_a_ready}, 84'd1);
        tick();
        in_a_valid = 1'b0;
        check("t2_head_b3", out_a_bits, b3);
        tick();
        check("t2_drained", {83'd0, out_a_valid}, 84'd0);
        check("t2_inflight", {80'd0, inflight}, 84'd3);

        // Inflight limit
        do_reset();
        out_a_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_a_bits  = mk_a(3'd4, 5'(i), 32'h1000 + 32'(i * 4), 4'hF, 32'(i));
            in_a_valid = 1'b1;
            tick();
        end
        in_a_valid = 1'b0;
        tick();
        tick();
        check("t3_fires", 84'(m_a_fires), 84'd4);
        check("t3_inflight", {80'd0, inflight}, 84'd4);
        check("t3_gated", {83'd0, out_a_valid}, 84'd0);
        check("t3_a_full", {83'd0, in_a_ready}, 84'd0);
        out_d_ready = 1'b1;
        in_d_bits   = mk_d(3'd1, 5'd0, 32'hCAFE);
        in_d_valid  = 1'b1;
        tick();
        in_d_valid = 1'b0;
        check("t3_infl_after_d", {80'd0, inflight}, 84'd3);
        check("t3_ungated", {83'd0, out_a_valid}, 84'd1);
        tick();
        check("t3_fifth_fire", 84'(m_a_fires), 84'd5);
        check("t3_infl_back", {80'd0, inflight}, 84'd4);

        // Simultaneous A fire and D fire
        do_reset();
        out_a_ready = 1'b1;
        out_d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a_bits  = mk_a(3'd0, 5'(i), 32'h2000 + 32'(i * 4), 4'hF, 32'h55 + 32'(i));
            in_a_valid = 1'b1;
            tick();
        end
        in_a_valid = 1'b0;
        check("t4_infl_pre", {80'd0, inflight}, 84'd2);
        check("t4_a_pending", {83'd0, out_a_valid}, 84'd1);
        in_d_bits  = mk_d(3'd0, 5'd0, 32'd0);
        in_d_valid = 1'b1;
        tick();
        in_d_valid = 1'b0;
        check("t4_infl_same", {80'd0, inflight}, 84'd2);
        tick();

        // Unexpected D from reset
        do_reset();
        gd = mk_d(3'd1, 5'd3, 32'hDEAD_BEEF);
        in_d_bits  = gd;
        in_d_valid = 1'b1;
        tick();
        in_d_valid = 1'b0;
        check("t5_out_d_valid", {83'd0, out_d_valid}, 84'd1);
        check("t5_out_d_bits", {35'd0, out_d_bits}, {35'd0, gd});
        check("t5_err", {83'd0, err_unexpected_d}, 84'd1);
        check("t5_inflight", {80'd0, inflight}, 84'd0);
        out_d_ready = 1'b1;
        tick();
        tick();
        check("t5_err_sticky", {83'd0, err_unexpected_d}, 84'd1);

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 2; i++) begin
            in_d_bits  = mk_d(3'd1, 5'(i), 32'h700 + 32'(i));
            in_d_valid = 1'b1;
            tick();
        end
        in_d_valid  = 1'b0;
        out_a_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) out_a_ready = 1'b0;
            in_a_bits  = mk_a(3'd4, 5'(i), 32'h3000 + 32'(i * 4), 4'hF, 32'(i));
            in_a_valid = 1'b1;
            tick();
        end
        in_a_valid = 1'b0;
        check("t6_infl_pre", {80'd0, inflight}, 84'd3);
        check("t6_a_full", {83'd0, in_a_ready}, 84'd0);
        check("t6_d_full", {83'd0, in_d_ready}, 84'd0);
        check("t6_err_pre", {83'd0, err_unexpected_d}, 84'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_out_a_valid", {83'd0, out_a_valid}, 84'd0);
        check("t6_out_d_valid", {83'd0, out_d_valid}, 84'd0);
        check("t6_inflight", {80'd0, inflight}, 84'd0);
        check("t6_in_a_ready", {83'd0, in_a_ready}, 84'd1);
        check("t6_in_d_ready", {83'd0, in_d_ready}, 84'd1);
        check("t6_err", {83'd0, err_unexpected_d}, 84'd0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
